ahb_lite_cmd_master: RTL and testbench



---
 rtl/ahb_lite_pkg.sv | 25 ++
 rtl/ahb_lite_interface.sv | 26 ++
 rtl/ahb_lite_cmd_master.sv | 142 ++++++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the command record used by the bus initiator.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Command records carry a 32-bit address; narrower buses zero-extend into it.
  localparam int AHB_CMD_ADDR_W = 32;

  typedef struct packed {
    logic [AHB_CMD_ADDR_W-1:0] addr;
    logic                      write;
    logic [2:0]                size;
    logic [31:0]               wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb_lite_interface.sv
// AHB-Lite bus bundle with master and slave views.
interface ahb_lite_interface #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [1:0]            htrans;
  logic [2:0]            hburst;
  logic                  hmastlock;
  logic [3:0]            hprot;
  logic [31:0]           hwdata;
  logic [31:0]           hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output haddr, hwrite, hsize, htrans, hburst, hmastlock, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, htrans, hburst, hmastlock, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// Single-transfer AHB-Lite initiator: valid/ready commands in, pipelined
// NONSEQ/SINGLE transfers out, one response pulse per transfer back.
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic                  hmastlock,
  output logic [3:0]            hprot,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  ahb_lite_interface #(.ADDR_WIDTH(ADDR_WIDTH)) u_bus ();

  ahb_cmd_t    ap_q, ap_d;
  logic        ap_valid_q, ap_valid_d;
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] dp_wdata_q, dp_wdata_d;
  logic        cancel_q, cancel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        cmd_fire;

  assign u_bus.hrdata = hrdata;
  assign u_bus.hready = hready;
  assign u_bus.hresp  = hresp;

  assign u_bus.haddr     = ADDR_WIDTH'(ap_q.addr);
  assign u_bus.hwrite    = ap_q.write;
  assign u_bus.hsize     = ap_q.size;
  assign u_bus.htrans    = (ap_valid_q && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign u_bus.hburst    = HBURST_SINGLE;
  assign u_bus.hmastlock = 1'b0;
  assign u_bus.hprot     = HPROT_VAL;
  assign u_bus.hwdata    = dp_wdata_q;

  assign haddr     = u_bus.haddr;
  assign hwrite    = u_bus.hwrite;
  assign hsize     = u_bus.hsize;
  assign htrans    = u_bus.htrans;
  assign hburst    = u_bus.hburst;
  assign hmastlock = u_bus.hmastlock;
  assign hprot     = u_bus.hprot;
  assign hwdata    = u_bus.hwdata;

  // No new command may enter while an error response is in progress or a
  // cancelled transfer is waiting to be re-issued.
  assign cmd_ready = u_bus.hready & ~u_bus.hresp & ~cancel_q;
  assign cmd_fire  = cmd_valid & cmd_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    ap_d        = ap_q;
    ap_valid_d  = ap_valid_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    cancel_d    = cancel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (u_bus.hready) begin
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = u_bus.hresp;
        rsp_rdata_d = dp_write_q ? 32'h0 : u_bus.hrdata;
      end
      if (cancel_q) begin
        // End of the error response: the retained address phase stays put
        // and is re-driven as NONSEQ on the following cycle.
        cancel_d   = 1'b0;
        dp_valid_d = 1'b0;
      end else begin
        dp_valid_d = ap_valid_q;
        if (ap_valid_q) begin
          dp_write_d = ap_q.write;
          dp_wdata_d = ap_q.wdata;
        end
        ap_valid_d = cmd_fire;
        if (cmd_fire) begin
          ap_d.addr  = AHB_CMD_ADDR_W'(cmd_addr);
          ap_d.write = cmd_write;
          ap_d.size  = cmd_size;
          ap_d.wdata = cmd_wdata;
        end
      end
    end else if (dp_valid_q && u_bus.hresp && ap_valid_q && !cancel_q) begin
      cancel_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      ap_q        <= '0;
      ap_valid_q  <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= 32'h0;
      cancel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      ap_q        <= ap_d;
      ap_valid_q  <= ap_valid_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      cancel_q    <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed and randomized checks of ahb_lite_cmd_master against a bench-side AHB slave.
module tb_ahb_lite_cmd_master;
  import ahb_lite_pkg::*;

  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [2:0]    cmd_size;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic          hmastlock;
  logic [3:0]    hprot;
  logic [31:0]   hwdata;
  logic [31:0]   hrdata;
  logic          hready;
  logic          hresp;

  int n_vec = 0;
  int n_err = 0;

  ahb_lite_cmd_master #(.ADDR_WIDTH(AW), .HPROT_VAL(4'b0011)) dut (
    .aclk(aclk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
    .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_size  = HSIZE_WORD;
    cmd_wdata = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_size = 3'd0; cmd_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    step(); step();
    n_vec++; if (htrans !== HTRANS_IDLE) begin n_err++; $display("FAIL reset_htrans: got %0h expected %0h", htrans, HTRANS_IDLE); end
    n_vec++; if (haddr !== 32'h0) begin n_err++; $display("FAIL reset_haddr: got %0h expected 0", haddr); end
    n_vec++; if ({hwrite, hsize, hburst, hmastlock} !== 8'h0) begin n_err++; $display("FAIL reset_ctrl: got %0h expected 0", {hwrite, hsize, hburst, hmastlock}); end
    n_vec++; if (hprot !== 4'b0011) begin n_err++; $display("FAIL reset_hprot: got %0h expected 3", hprot); end
    n_vec++; if (hwdata !== 32'h0) begin n_err++; $display("FAIL reset_hwdata: got %0h expected 0", hwdata); end
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin n_err++; $display("FAIL reset_rsp: got %0h expected 0", {rsp_valid, rsp_err, rsp_rdata}); end
    resetn = 1'b1;
    step();
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
  endtask

  task automatic test_single_read();
    hready = 1'b1; hresp = 1'b0;
    drive_cmd(32'h100, 1'b0, 32'h0);
    step();
    cmd_valid = 1'b0;
    n_vec++; if ({htrans, haddr, hwrite, hsize} !== {HTRANS_NONSEQ, 32'h100, 1'b0, HSIZE_WORD})
      begin n_err++; $display("FAIL single_aphase: got %0h expected %0h", {htrans, haddr, hwrite, hsize}, {HTRANS_NONSEQ, 32'h100, 1'b0, HSIZE_WORD}); end
    hrdata = 32'hCAFEF00D;
    step();
    n_vec++; if ({htrans, rsp_valid} !== {HTRANS_IDLE, 1'b0}) begin n_err++; $display("FAIL single_dphase: got %0h expected 0", {htrans, rsp_valid}); end
    step();
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D})
      begin n_err++; $display("FAIL single_rsp: got %0h expected %0h", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hCAFEF00D}); end
    hrdata = 32'h0;
    step();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_pulse: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    hready = 1'b1; hresp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive_cmd(32'(4 * i), 1'b1, 32'(i + 1));
      else cmd_valid = 1'b0;
      step();
      n_vec++;
      if (htrans !== ((i < 3) ? HTRANS_NONSEQ : HTRANS_IDLE)) begin n_err++; $display("FAIL b2b_htrans[%0d]: got %0h", i, htrans); end
      if (i < 3) begin
        n_vec++; if ({haddr, hwrite} !== {32'(4 * i), 1'b1}) begin n_err++; $display("FAIL b2b_haddr[%0d]: got %0h expected %0h", i, haddr, 4 * i); end
      end
      if (i >= 1 && i <= 3) begin
        n_vec++; if (hwdata !== 32'(i)) begin n_err++; $display("FAIL b2b_hwdata[%0d]: got %0h expected %0h", i, hwdata, i); end
      end
      n_vec++;
      if (rsp_valid !== (i >= 2 && i <= 4)) begin n_err++; $display("FAIL b2b_rsp_valid[%0d]: got %0b", i, rsp_valid); end
      else if (rsp_valid && {rsp_err, rsp_rdata} !== 33'h0) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %0h expected 0", i, {rsp_err, rsp_rdata}); end
    end
  endtask

  task automatic test_wait_states();
    hready = 1'b1; hresp = 1'b0;
    drive_cmd(32'h200, 1'b0, 32'h0);
    step();
    n_vec++; if ({htrans, haddr} !== {HTRANS_NONSEQ, 32'h200}) begin n_err++; $display("FAIL ws_aphase_a: got %0h", {htrans, haddr}); end
    drive_cmd(32'h204, 1'b0, 32'h0);
    step();
    cmd_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      n_vec++; if ({htrans, haddr, rsp_valid} !== {HTRANS_NONSEQ, 32'h204, 1'b0})
        begin n_err++; $display("FAIL ws_hold[%0d]: got %0h expected %0h", w, {htrans, haddr, rsp_valid}, {HTRANS_NONSEQ, 32'h204, 1'b0}); end
      if (w < 2) begin
        hready = 1'b0;
        #1;
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL ws_cmd_ready[%0d]: got %0b expected 0", w, cmd_ready); end
      end else begin
        hready = 1'b1; hrdata = 32'h12345678;
      end
      step();
    end
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata, htrans} !== {1'b1, 1'b0, 32'h12345678, HTRANS_IDLE})
      begin n_err++; $display("FAIL ws_rsp_a: got %0h", {rsp_valid, rsp_err, rsp_rdata, htrans}); end
    hrdata = 32'hAAAA5555;
    step();
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hAAAA5555})
      begin n_err++; $display("FAIL ws_rsp_b: got %0h", {rsp_valid, rsp_err, rsp_rdata}); end
    hrdata = 32'h0;
    step();
  endtask

  task automatic test_error();
    hready = 1'b1; hresp = 1'b0;
    drive_cmd(32'h10, 1'b1, 32'h55);
    step();
    drive_cmd(32'h14, 1'b0, 32'h0);
    step();
    cmd_valid = 1'b0;
    n_vec++; if ({htrans, haddr, hwrite, hwdata} !== {HTRANS_NONSEQ, 32'h14, 1'b0, 32'h55})
      begin n_err++; $display("FAIL err_pipeline: got %0h", {htrans, haddr, hwrite, hwdata}); end
    hready = 1'b0; hresp = 1'b1;
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL err_cmd_ready: got %0b expected 0", cmd_ready); end
    step();
    n_vec++; if ({htrans, haddr} !== {HTRANS_IDLE, 32'h14}) begin n_err++; $display("FAIL err_cancel: got %0h expected %0h", {htrans, haddr}, {HTRANS_IDLE, 32'h14}); end
    hready = 1'b1; hresp = 1'b1;
    step();
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin n_err++; $display("FAIL err_rsp_write: got %0h", {rsp_valid, rsp_err, rsp_rdata}); end
    n_vec++; if ({htrans, haddr, hwrite} !== {HTRANS_NONSEQ, 32'h14, 1'b0}) begin n_err++; $display("FAIL err_reissue: got %0h", {htrans, haddr, hwrite}); end
    hresp = 1'b0;
    step();
    n_vec++; if ({rsp_valid, htrans} !== {1'b0, HTRANS_IDLE}) begin n_err++; $display("FAIL err_reissue_dphase: got %0h", {rsp_valid, htrans}); end
    hrdata = 32'h0BADBEEF;
    step();
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0BADBEEF}) begin n_err++; $display("FAIL err_rsp_read: got %0h", {rsp_valid, rsp_err, rsp_rdata}); end
    hrdata = 32'h0;
    step();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL err_tail: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    hready = 1'b1; hresp = 1'b0;
    drive_cmd(32'h300, 1'b1, 32'hDEADBEEF);
    step();
    drive_cmd(32'h304, 1'b0, 32'h0);
    step();
    cmd_valid = 1'b0;
    n_vec++; if ({htrans, hwdata} !== {HTRANS_NONSEQ, 32'hDEADBEEF}) begin n_err++; $display("FAIL rstmid_dphase: got %0h", {htrans, hwdata}); end
    hready = 1'b0;
    #2 resetn = 1'b0;
    #1;
    n_vec++; if ({htrans, haddr, hwdata, rsp_valid, rsp_err, rsp_rdata} !== '0)
      begin n_err++; $display("FAIL rstmid_async: got %0h expected 0", {htrans, haddr, hwdata, rsp_valid, rsp_err, rsp_rdata}); end
    #1 resetn = 1'b1;
    hready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++; if ({rsp_valid, htrans} !== {1'b0, HTRANS_IDLE}) begin n_err++; $display("FAIL rstmid_no_rsp[%0d]: got %0h", k, {rsp_valid, htrans}); end
    end
    drive_cmd(32'h400, 1'b0, 32'h0);
    step();
    cmd_valid = 1'b0;
    hrdata = 32'h13572468;
    step();
    step();
    n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h13572468}) begin n_err++; $display("FAIL rstmid_after: got %0h", {rsp_valid, rsp_err, rsp_rdata}); end
    hrdata = 32'h0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] smem [16];
    logic [31:0] rmem [16];
    logic [32:0] expq [$];
    logic [32:0] exp_rsp;
    logic        dp_pend, dp_wr, err2, acc, pr_hready, pr_hresp, w_cap, e;
    logic [3:0]  dp_idx, ix;
    logic [1:0]  t_cap, pr_htrans;
    logic [31:0] a_cap, wd_cap, pr_haddr;
    for (int i = 0; i < 16; i++) begin
      smem[i] = 32'h5A00_0000 + 32'(i * 17);
      rmem[i] = 32'h5A00_0000 + 32'(i * 17);
    end
    dp_pend = 1'b0; dp_wr = 1'b0; err2 = 1'b0; dp_idx = '0;
    pr_hready = 1'b1; pr_hresp = 1'b0; pr_htrans = htrans; pr_haddr = haddr;
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (!dp_pend) begin hready = 1'b1; hresp = 1'b0; hrdata = 32'h0; end
      else if (err2) begin hready = 1'b1; hresp = 1'b1; hrdata = 32'h0; end
      else if ($urandom_range(3) == 0) begin hready = 1'b0; hresp = 1'b0; hrdata = $urandom; end
      else if (dp_idx == 4'hF) begin hready = 1'b0; hresp = 1'b1; hrdata = 32'h0; end
      else begin hready = 1'b1; hresp = 1'b0; hrdata = dp_wr ? $urandom : smem[dp_idx]; end
      if (!cmd_valid && cyc < 500 && $urandom_range(3) != 0) begin
        ix = 4'($urandom_range(15));
        drive_cmd({26'h0, ix, 2'b00}, 1'($urandom_range(1)), $urandom);
      end
      #1;
      acc = cmd_valid & cmd_ready;
      if (!pr_hready && !pr_hresp) begin
        n_vec++; if ({htrans, haddr} !== {pr_htrans, pr_haddr})
          begin n_err++; $display("FAIL rnd_stall_stable[%0d]: got %0h expected %0h", cyc, {htrans, haddr}, {pr_htrans, pr_haddr}); end
      end
      n_vec++; if (htrans == HTRANS_BUSY || htrans == HTRANS_SEQ || hburst !== HBURST_SINGLE || hmastlock !== 1'b0)
        begin n_err++; $display("FAIL rnd_protocol[%0d]: got %0h", cyc, {htrans, hburst, hmastlock}); end
      if (acc) begin
        ix = cmd_addr[5:2];
        e = (ix == 4'hF);
        expq.push_back({e, (cmd_write || e) ? 32'h0 : rmem[ix]});
        if (cmd_write && !e) rmem[ix] = cmd_wdata;
      end
      t_cap = htrans; a_cap = haddr; w_cap = hwrite; wd_cap = hwdata;
      pr_hready = hready; pr_hresp = hresp; pr_htrans = htrans; pr_haddr = haddr;
      step();
      if (acc) cmd_valid = 1'b0;
      if (pr_hready) begin
        if (dp_pend && !pr_hresp && dp_wr) smem[dp_idx] = wd_cap;
        dp_pend = (t_cap == HTRANS_NONSEQ);
        dp_idx  = a_cap[5:2];
        dp_wr   = w_cap;
        err2    = 1'b0;
      end else if (pr_hresp) begin
        err2 = 1'b1;
      end
      if (rsp_valid) begin
        n_vec++;
        if (expq.size() == 0) begin n_err++; $display("FAIL rnd_unexpected_rsp[%0d]: got %0h expected none", cyc, {rsp_err, rsp_rdata}); end
        else begin
          exp_rsp = expq.pop_front();
          if ({rsp_err, rsp_rdata} !== exp_rsp) begin n_err++; $display("FAIL rnd_rsp[%0d]: got %0h expected %0h", cyc, {rsp_err, rsp_rdata}, exp_rsp); end
        end
      end
    end
    n_vec++; if (expq.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d outstanding expected 0", expq.size()); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
